// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, ALU function codes,
// FSM states, mux selects and instruction classes.
package ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FUNC_W  = 5;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_ADDI = 4'h3,
    OP_ANDI = 4'h4, OP_LW   = 4'h5, OP_LB   = 4'h6, OP_SW   = 4'h7,
    OP_BLZ  = 4'h8, OP_BLE  = 4'h9, OP_BEQ  = 4'hA, OP_BLTU = 4'hB,
    OP_JMP  = 4'hC, OP_CALL = 4'hD, OP_RET  = 4'hE, OP_SV   = 4'hF
  } opcode_e;

  // ALU function code = {opcode, mode} where mode is meaningful, else {opcode, 0}
  typedef enum logic [FUNC_W-1:0] {
    F_AND  = 5'b00000, F_ADD  = 5'b00010, F_SUB  = 5'b00100, F_ADDI = 5'b00110,
    F_ANDI = 5'b01000, F_LW   = 5'b01010, F_LBU  = 5'b01100, F_LBS  = 5'b01101,
    F_SW   = 5'b01110, F_BLTZ = 5'b10000, F_BGTZ = 5'b10001, F_BLEZ = 5'b10010,
    F_BGEZ = 5'b10011, F_BEQ  = 5'b10100, F_BNE  = 5'b10101, F_BLTU = 5'b10110,
    F_BGEU = 5'b10111, F_JMP  = 5'b11000, F_CALL = 5'b11010, F_RET  = 5'b11100,
    F_SV   = 5'b11110
  } alu_func_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [1:0] PC_PLUS2  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  typedef enum logic [3:0] {
    CL_R, CL_IMM, CL_LOAD, CL_STORE, CL_SV, CL_BRANCH, CL_JMP, CL_CALL, CL_RET
  } instr_class_e;

  typedef struct packed {
    opcode_e     opcode;
    logic        mode;
    logic [10:0] rest;
  } instr_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface multicycle_ctrl_if;
  import ctrl_pkg::*;

  instr_t              instr;
  logic                mem_ready;
  logic                take_branch;
  logic [FUNC_W-1:0]   alu_func;
  logic                alu_b_src;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                mem_read;
  logic                mem_write;
  logic                mem_addr_src;
  logic                mem_byte;
  logic                mem_sign;
  logic                reg_write;
  logic [1:0]          wb_src;
  logic [2:0]          dst_link;
  logic                mem_err;
  logic [2:0]          state;

  modport master (
    input  instr, mem_ready, take_branch,
    output alu_func, alu_b_src, ir_write, pc_write, pc_src, mem_read, mem_write,
           mem_addr_src, mem_byte, mem_sign, reg_write, wb_src, dst_link, mem_err, state
  );

  modport slave (
    output instr, mem_ready, take_branch,
    input  alu_func, alu_b_src, ir_write, pc_write, pc_src, mem_read, mem_write,
           mem_addr_src, mem_byte, mem_sign, reg_write, wb_src, dst_link, mem_err, state
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: latched opcode/mode -> ALU function code and class.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  opcode_e             opcode_i,
  input  logic                mode_i,
  output logic [FUNC_W-1:0]   alu_func_o,
  output instr_class_e        cls_o
);

  logic mode_used;

  always_comb begin
    mode_used = 1'b0;
    cls_o     = CL_R;
    case (opcode_i)
      OP_AND, OP_ADD, OP_SUB:       cls_o = CL_R;
      OP_ADDI, OP_ANDI:             cls_o = CL_IMM;
      OP_LW:                        cls_o = CL_LOAD;
      OP_LB: begin
        cls_o     = CL_LOAD;
        mode_used = 1'b1;
      end
      OP_SW:                        cls_o = CL_STORE;
      OP_BLZ, OP_BLE, OP_BEQ, OP_BLTU: begin
        cls_o     = CL_BRANCH;
        mode_used = 1'b1;
      end
      OP_JMP:                       cls_o = CL_JMP;
      OP_CALL:                      cls_o = CL_CALL;
      OP_RET:                       cls_o = CL_RET;
      OP_SV:                        cls_o = CL_SV;
      default:                      cls_o = CL_R;
    endcase
    // mode only selects a function variant for byte loads and branches
    alu_func_o = {opcode_i, mode_i & mode_used};
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready watchdog;
// strobes are Moore on state plus Mealy on mem_ready (FETCH/MEM) and take_branch (EXEC).
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned LINK_REG   = 7
)(
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_e             state_q, state_d;
  opcode_e            opcode_q;
  logic               mode_q;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ir_load;
  logic               waiting;
  logic [FUNC_W-1:0]  dec_func;
  instr_class_e       dec_cls;
  logic               unused_instr_bits;

  assign unused_instr_bits = ^bus.instr.rest;

  ctrl_decode u_decode (
    .opcode_i   (opcode_q),
    .mode_i     (mode_q),
    .alu_func_o (dec_func),
    .cls_o      (dec_cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= OP_AND;
      mode_q    <= 1'b0;
      mem_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_d;
      cnt_q     <= cnt_d;
      if (ir_load) begin
        opcode_q <= bus.instr.opcode;
        mode_q   <= bus.instr.mode;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    mem_err_d        = mem_err_q;
    cnt_d            = '0;
    waiting          = 1'b0;
    ir_load          = 1'b0;
    bus.alu_func     = '0;
    bus.alu_b_src    = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = PC_PLUS2;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_addr_src = 1'b0;
    bus.mem_byte     = 1'b0;
    bus.mem_sign     = 1'b0;
    bus.reg_write    = 1'b0;
    bus.wb_src       = WB_ALU;
    bus.dst_link     = '0;

    case (state_q)
      ST_FETCH: begin
        bus.mem_read = 1'b1;
        // rst_n gate keeps the fetch strobes quiet while reset holds state in FETCH
        if (bus.mem_ready && rst_n) begin
          ir_load      = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = ST_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_DECODE: begin
        bus.alu_func = dec_func;
        state_d      = ST_EXEC;
      end
      ST_EXEC: begin
        bus.alu_func = dec_func;
        state_d      = ST_FETCH;
        case (dec_cls)
          CL_R:     state_d = ST_WB;
          CL_IMM: begin
            bus.alu_b_src = 1'b1;
            state_d       = ST_WB;
          end
          CL_LOAD, CL_STORE: begin
            bus.alu_b_src = 1'b1;
            state_d       = ST_MEM;
          end
          CL_SV:    state_d = ST_MEM;
          CL_BRANCH: begin
            bus.pc_write = bus.take_branch;
            bus.pc_src   = PC_BRANCH;
          end
          CL_JMP: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = PC_ALU;
          end
          CL_CALL: begin
            bus.pc_write  = 1'b1;
            bus.pc_src    = PC_ALU;
            bus.reg_write = 1'b1;
            bus.wb_src    = WB_LINK;
            bus.dst_link  = 3'(LINK_REG);
          end
          CL_RET: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = PC_REG;
          end
          default:  state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        bus.alu_func     = dec_func;
        bus.mem_addr_src = 1'b1;
        if (dec_cls == CL_LOAD) begin
          bus.mem_read = 1'b1;
          bus.mem_byte = (opcode_q == OP_LB);
          bus.mem_sign = (opcode_q == OP_LB) && mode_q;
        end else begin
          bus.mem_write = 1'b1;
        end
        if (bus.mem_ready) begin
          state_d = (dec_cls == CL_LOAD) ? ST_WB : ST_FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_WB: begin
        bus.alu_func  = dec_func;
        bus.reg_write = 1'b1;
        bus.wb_src    = (dec_cls == CL_LOAD) ? WB_MEM : WB_ALU;
        state_d       = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // watchdog: abort to FETCH on the WAIT_LIMIT-th consecutive not-ready cycle
    if (waiting && (WAIT_LIMIT != 0)) begin
      if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
        state_d   = ST_FETCH;
        mem_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.ir_write = ir_load;
  assign bus.mem_err  = mem_err_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, reset corner cases, then random
// instruction streams checked against a per-instruction phase expansion of the rules.
module tb_multicycle_ctrl;

  localparam int WL   = 4;
  localparam int LINK = 7;

  typedef struct packed {
    logic [2:0] state;
    logic [4:0] alu_func;
    logic       alu_b_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_addr_src;
    logic       mem_byte;
    logic       mem_sign;
    logic       reg_write;
    logic [1:0] wb_src;
    logic [2:0] dst_link;
    logic       mem_err;
  } exp_t;

  typedef struct packed {
    logic [15:0] instr;
    logic        rdy;
    logic        tk;
    exp_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   merr = 1'b0;
  vec_t tbl[$];
  vec_t rq[$];

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.WAIT_LIMIT(WL), .LINK_REG(LINK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input int st, input int fn, input bit bs, input bit irw,
                              input bit pcw, input int pcs, input bit mr, input bit mw,
                              input bit mas, input bit mb, input bit ms, input bit rw,
                              input int wbs, input int dl, input bit err);
    exp_t r;
    r.state = 3'(st);      r.alu_func = 5'(fn);   r.alu_b_src = bs;
    r.ir_write = irw;      r.pc_write = pcw;      r.pc_src = 2'(pcs);
    r.mem_read = mr;       r.mem_write = mw;      r.mem_addr_src = mas;
    r.mem_byte = mb;       r.mem_sign = ms;       r.reg_write = rw;
    r.wb_src = 2'(wbs);    r.dst_link = 3'(dl);   r.mem_err = err;
    return r;
  endfunction

  function automatic vec_t v(input logic [15:0] i, input bit r, input bit t, input exp_t e);
    vec_t x;
    x.instr = i; x.rdy = r; x.tk = t; x.exp = e;
    return x;
  endfunction

  function automatic exp_t sample();
    exp_t r;
    r.state = bus.state;          r.alu_func = bus.alu_func;   r.alu_b_src = bus.alu_b_src;
    r.ir_write = bus.ir_write;    r.pc_write = bus.pc_write;   r.pc_src = bus.pc_src;
    r.mem_read = bus.mem_read;    r.mem_write = bus.mem_write; r.mem_addr_src = bus.mem_addr_src;
    r.mem_byte = bus.mem_byte;    r.mem_sign = bus.mem_sign;   r.reg_write = bus.reg_write;
    r.wb_src = bus.wb_src;        r.dst_link = bus.dst_link;   r.mem_err = bus.mem_err;
    return r;
  endfunction

  task automatic check(input exp_t e, input string nm, input int idx);
    exp_t g;
    g = sample();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, g, e);
    end
  endtask

  // called at a falling edge: drive, let comb outputs settle, compare, advance one cycle
  task automatic apply(input vec_t t, input string nm, input int idx);
    bus.instr       = t.instr;
    bus.mem_ready   = t.rdy;
    bus.take_branch = t.tk;
    #2;
    check(t.exp, nm, idx);
    @(negedge clk);
  endtask

  // expands one instruction into its per-cycle expected outputs, given stall counts
  task automatic gen(input logic [15:0] ins, input bit take, input int fst, input int mst);
    logic [3:0] op;
    bit md, ld, st, br, bs, pcw, rw, to_wb, mb, ms;
    int fn, pcs, wbs, dl;
    op  = ins[15:12];
    md  = ins[11];
    ld  = (op == 4'd5) || (op == 4'd6);
    st  = (op == 4'd7) || (op == 4'd15);
    br  = (op >= 4'd8) && (op <= 4'd11);
    fn  = int'(op) * 2 + (((op == 4'd6) || br) && md ? 1 : 0);
    for (int i = 0; i < fst && i < WL; i++)
      rq.push_back(v(16'($urandom), 1'b0, 1'($urandom), ex(0,0,0,0,0,0,1,0,0,0,0,0,0,0,merr)));
    if (fst >= WL) begin
      merr = 1'b1;
      return;
    end
    rq.push_back(v(ins, 1'b1, 1'($urandom), ex(0,0,0,1,1,0,1,0,0,0,0,0,0,0,merr)));
    rq.push_back(v(16'($urandom), 1'($urandom), 1'($urandom), ex(1,fn,0,0,0,0,0,0,0,0,0,0,0,0,merr)));
    bs    = (op >= 4'd3) && (op <= 4'd7);
    pcw   = br ? take : ((op >= 4'd12) && (op <= 4'd14));
    pcs   = br ? 1 : (op == 4'd14) ? 3 : ((op == 4'd12) || (op == 4'd13)) ? 2 : 0;
    rw    = (op == 4'd13);
    wbs   = rw ? 2 : 0;
    dl    = rw ? LINK : 0;
    to_wb = (op <= 4'd4);
    rq.push_back(v(16'($urandom), 1'($urandom), take, ex(2,fn,bs,0,pcw,pcs,0,0,0,0,0,rw,wbs,dl,merr)));
    if (ld || st) begin
      mb = (op == 4'd6);
      ms = mb && md;
      for (int i = 0; i < mst && i < WL; i++)
        rq.push_back(v(16'($urandom), 1'b0, 1'($urandom), ex(3,fn,0,0,0,0,ld,!ld,1,mb,ms,0,0,0,merr)));
      if (mst >= WL) begin
        merr = 1'b1;
        return;
      end
      rq.push_back(v(16'($urandom), 1'b1, 1'($urandom), ex(3,fn,0,0,0,0,ld,!ld,1,mb,ms,0,0,0,merr)));
      to_wb = ld;
    end
    if (to_wb)
      rq.push_back(v(16'($urandom), 1'($urandom), 1'($urandom), ex(4,fn,0,0,0,0,0,0,0,0,0,1,ld ? 1 : 0,0,merr)));
  endtask

  initial begin
    exp_t f0, idle;
    f0   = ex(0,0,0,1,1,0,1,0,0,0,0,0,0,0,0);
    idle = ex(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0);

    // ADD 0x1234
    tbl.push_back(v(16'h1234, 1, 0, f0));
    tbl.push_back(v(16'h0000, 1, 1, ex(1,2,0,0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(v(16'hFFFF, 1, 1, ex(2,2,0,0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(v(16'hFFFF, 1, 1, ex(4,2,0,0,0,0,0,0,0,0,0,1,0,0,0)));
    // BEQ taken, then not taken
    tbl.push_back(v(16'hA000, 1, 0, f0));
    tbl.push_back(v(16'h0000, 1, 0, ex(1,20,0,0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(v(16'h0000, 1, 1, ex(2,20,0,0,1,1,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(v(16'hA000, 1, 1, f0));
    tbl.push_back(v(16'h0000, 1, 1, ex(1,20,0,0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(v(16'h0000, 1, 0, ex(2,20,0,0,0,1,0,0,0,0,0,0,0,0,0)));
    // CALL
    tbl.push_back(v(16'hD005, 1, 0, f0));
    tbl.push_back(v(16'h0000, 1, 0, ex(1,26,0,0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(v(16'h0000, 1, 0, ex(2,26,0,0,1,2,0,0,0,0,0,1,2,7,0)));
    // ADD with mode bit set: mode ignored
    tbl.push_back(v(16'h1800, 1, 0, f0));
    tbl.push_back(v(16'h0000, 1, 0, ex(1,2,0,0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(v(16'h0000, 1, 0, ex(2,2,0,0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(v(16'h0000, 1, 0, ex(4,2,0,0,0,0,0,0,0,0,0,1,0,0,0)));
    // BGTZ: mode selects the variant
    tbl.push_back(v(16'h8800, 1, 0, f0));
    tbl.push_back(v(16'h0000, 1, 0, ex(1,17,0,0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(v(16'h0000, 1, 1, ex(2,17,0,0,1,1,0,0,0,0,0,0,0,0,0)));
    // LBs with three not-ready MEM cycles
    tbl.push_back(v(16'h6800, 1, 0, f0));
    tbl.push_back(v(16'h0000, 1, 0, ex(1,13,0,0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(v(16'h0000, 1, 0, ex(2,13,1,0,0,0,0,0,0,0,0,0,0,0,0)));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(16'h0000, (i == 3), 0, ex(3,13,0,0,0,0,1,0,1,1,1,0,0,0,0)));
    tbl.push_back(v(16'h0000, 1, 0, ex(4,13,0,0,0,0,0,0,0,0,0,1,1,0,0)));
    // SW starved by memory: watchdog aborts after WL MEM cycles
    tbl.push_back(v(16'h7000, 1, 0, f0));
    tbl.push_back(v(16'h0000, 1, 0, ex(1,14,0,0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(v(16'h0000, 1, 0, ex(2,14,1,0,0,0,0,0,0,0,0,0,0,0,0)));
    for (int i = 0; i < WL; i++)
      tbl.push_back(v(16'h0000, 0, 0, ex(3,14,0,0,0,0,0,1,1,0,0,0,0,0,0)));
    tbl.push_back(v(16'h0000, 0, 0, ex(0,0,0,0,0,0,1,0,0,0,0,0,0,0,1)));
    tbl.push_back(v(16'h0000, 0, 0, ex(0,0,0,0,0,0,1,0,0,0,0,0,0,0,1)));

    // reset with mem_ready high: only mem_read may be set
    rst_n           = 1'b0;
    bus.instr       = 16'h1234;
    bus.mem_ready   = 1'b1;
    bus.take_branch = 1'b1;
    #3;
    check(idle, "reset_outputs", 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], "table", i);

    // Sv stalled in MEM, then reset lands mid-cycle: strobes drop at once, mem_err clears
    apply(v(16'hF123, 1, 0, ex(0,0,0,1,1,0,1,0,0,0,0,0,0,0,1)), "sv_seq", 0);
    apply(v(16'h0000, 1, 0, ex(1,30,0,0,0,0,0,0,0,0,0,0,0,0,1)), "sv_seq", 1);
    apply(v(16'h0000, 1, 0, ex(2,30,0,0,0,0,0,0,0,0,0,0,0,0,1)), "sv_seq", 2);
    apply(v(16'h0000, 0, 0, ex(3,30,0,0,0,0,0,1,1,0,0,0,0,0,1)), "sv_seq", 3);
    bus.mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check(idle, "reset_mid_mem", 0);
    @(negedge clk);
    rst_n = 1'b1;
    merr  = 1'b0;

    // random instruction stream with random stalls, some long enough to trip the watchdog
    for (int n = 0; n < 80; n++) begin
      int fst, mst;
      fst = ($urandom_range(0, 7) == 0) ? $urandom_range(WL, WL + 1) : $urandom_range(0, 2);
      mst = ($urandom_range(0, 7) == 0) ? $urandom_range(WL, WL + 1) : $urandom_range(0, 3);
      gen(16'($urandom), 1'($urandom), fst, mst);
    end
    foreach (rq[i]) apply(rq[i], "random", i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
